// File: rtl/hdlc_rx_deframer_pkg.sv
// Shared definitions for the HDLC receive deframer: one-hot detector state indices,
// CRC-16/X.25 constants and the receiver mode type.
package hdlc_pkg;

    localparam int S0      = 0;
    localparam int S1      = 1;
    localparam int S2      = 2;
    localparam int S3      = 3;
    localparam int S4      = 4;
    localparam int S5      = 5;
    localparam int S6      = 6;
    localparam int ERR     = 7;
    localparam int DISC    = 8;
    localparam int FLAG    = 9;
    localparam int NSTATES = 10;

    localparam logic [15:0] CRC_INIT     = 16'hFFFF;
    localparam logic [15:0] CRC_POLY_REV = 16'h8408;
    localparam logic [15:0] CRC_GOOD     = 16'hF0B8;

    typedef enum logic {
        HUNT,
        SYNC
    } rx_mode_e;

    // One LSB-first bit step of the reflected CRC-16/X.25.
    function automatic logic [15:0] crc16_bit(input logic [15:0] crc, input logic b);
        return (crc[0] ^ b) ? ((crc >> 1) ^ CRC_POLY_REV) : (crc >> 1);
    endfunction

endpackage

// File: rtl/hdlc_rx_deframer_if.sv
// Serial-bit input and byte-output bundle of the HDLC receive deframer.
// master = sampler/consumer side, slave = deframer side.
interface hdlc_rx_deframer_if;
    logic       in_valid;
    logic       in;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_sof;
    logic       out_eof;
    logic       out_abort;
    logic       out_crc_err;
    logic       in_frame;

    modport master (
        output in_valid, in,
        input  out_valid, out_data, out_sof, out_eof, out_abort, out_crc_err, in_frame
    );

    modport slave (
        input  in_valid, in,
        output out_valid, out_data, out_sof, out_eof, out_abort, out_crc_err, in_frame
    );
endinterface

// File: rtl/hdlc_rx_deframer_det.sv
// hdlc_onehot_det: registered one-hot ones-run detector that classifies each line bit
// as data, stuffed zero (DISC), flag (FLAG) or abort run (ERR).
module hdlc_onehot_det
    import hdlc_pkg::*;
(
    input  logic               clk,
    input  logic               aresetn,
    input  logic               in_valid,
    input  logic               in,
    output logic [NSTATES-1:0] state,
    output logic [NSTATES-1:0] next_state
);

    always_comb begin
        // NOTE: assigning the whole vector before any branch keeps this block free of latches.
        next_state = '0;
        if (in) begin
            next_state[S1]  = state[S0] | state[DISC] | state[FLAG];
            next_state[S2]  = state[S1];
            next_state[S3]  = state[S2];
            next_state[S4]  = state[S3];
            next_state[S5]  = state[S4];
            next_state[S6]  = state[S5];
            next_state[ERR] = state[S6] | state[ERR];
        end else begin
            next_state[DISC] = state[S5];
            next_state[FLAG] = state[S6];
            next_state[S0]   = ~(state[S5] | state[S6]);
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        // NOTE: non-blocking updates so every register samples pre-edge values.
        if (!aresetn) begin
            state <= NSTATES'(1);
        end else if (in_valid) begin
            state <= next_state;
        end
    end

endmodule

// File: rtl/hdlc_rx_deframer.sv
// HDLC receive deframer: drops stuffed zeros, strips flags, packs bytes LSB-first and
// reports SOF/EOF/abort. Optional FCS check enabled by defining HDLC_RX_CRC16_EN.
module hdlc_rx_deframer
    import hdlc_pkg::*;
#(
    parameter int MAX_BYTES = 256
) (
    input logic               clk,
    input logic               aresetn,
    hdlc_rx_deframer_if.slave bus
);

    localparam int                 DLY       = 7;
    localparam int                 CW        = $clog2(MAX_BYTES + 1);
    localparam logic [CW-1:0]      MAX_CNT   = CW'(MAX_BYTES);
    localparam logic [NSTATES-1:0] ERR_OH    = NSTATES'(1) << ERR;
    localparam logic [NSTATES-1:0] PUSH_MASK = (NSTATES'(1) << (S6 + 1)) - NSTATES'(1);

    logic [NSTATES-1:0] det_state, det_next;
    logic               ev_flag, ev_abort, ev_push;

    hdlc_onehot_det u_det (
        .clk       (clk),
        .aresetn   (aresetn),
        .in_valid  (bus.in_valid),
        .in        (bus.in),
        .state     (det_state),
        .next_state(det_next)
    );

    assign ev_flag  = det_next[FLAG];
    assign ev_abort = det_next[ERR] && (det_state != ERR_OH);
    assign ev_push  = |(det_next & PUSH_MASK);

    rx_mode_e         mode_q, mode_d;
    logic [DLY-1:0]   dly_q, dly_d;
    logic [2:0]       dly_cnt_q, dly_cnt_d;
    logic [6:0]       pack_q, pack_d;
    logic [2:0]       pack_cnt_q, pack_cnt_d;
    logic [7:0]       hold_q, hold_d;
    logic             hold_vld_q, hold_vld_d;
    logic             hold_first_q, hold_first_d;
    logic [CW-1:0]    byte_cnt_q, byte_cnt_d;
    logic             in_frame_q, in_frame_d;
    logic             out_valid_q, out_valid_d;
    logic [7:0]       out_data_q, out_data_d;
    logic             out_sof_q, out_sof_d;
    logic             out_eof_q, out_eof_d;
    logic             out_abort_q, out_abort_d;
    logic [7:0]       byte_v;
    logic             clr;
`ifdef HDLC_RX_CRC16_EN
    logic [15:0]      crc_q, crc_d;
    logic             crc_err_q, crc_err_d;
`endif

    always_comb begin
        mode_d       = mode_q;
        dly_d        = dly_q;
        dly_cnt_d    = dly_cnt_q;
        pack_d       = pack_q;
        pack_cnt_d   = pack_cnt_q;
        hold_d       = hold_q;
        hold_vld_d   = hold_vld_q;
        hold_first_d = hold_first_q;
        byte_cnt_d   = byte_cnt_q;
        in_frame_d   = in_frame_q;
        out_valid_d  = 1'b0;
        out_data_d   = out_data_q;
        out_sof_d    = 1'b0;
        out_eof_d    = 1'b0;
        out_abort_d  = 1'b0;
        clr          = 1'b0;
        byte_v       = {dly_q[DLY-1], pack_q};
`ifdef HDLC_RX_CRC16_EN
        crc_d        = crc_q;
        crc_err_d    = 1'b0;
`endif
        if (bus.in_valid) begin
            unique case (mode_q)
                HUNT: begin
                    if (ev_flag) begin
                        mode_d = SYNC;
                        clr    = 1'b1;
                    end
                end
                SYNC: begin
                    if (ev_flag) begin
                        if (pack_cnt_q == 3'd0 && hold_vld_q) begin
                            out_valid_d = 1'b1;
                            out_data_d  = hold_q;
                            out_sof_d   = hold_first_q;
                            out_eof_d   = 1'b1;
`ifdef HDLC_RX_CRC16_EN
                            crc_err_d   = (byte_cnt_q < CW'(3)) || (crc_q != CRC_GOOD);
`endif
                        end else if (pack_cnt_q != 3'd0) begin
                            out_abort_d = 1'b1;
                        end
                        clr = 1'b1;
                    end else if (ev_abort) begin
                        out_abort_d = in_frame_q || hold_vld_q || (pack_cnt_q != 3'd0);
                        mode_d      = HUNT;
                        clr         = 1'b1;
                    end else if (ev_push) begin
                        dly_d = {dly_q[DLY-2:0], bus.in};
                        if (dly_cnt_q != 3'd7) begin
                            dly_cnt_d = dly_cnt_q + 3'd1;
                        end else begin
                            // Oldest delayed bit is now known not to be part of a flag.
                            pack_d     = byte_v[7:1];
                            pack_cnt_d = pack_cnt_q + 3'd1;
`ifdef HDLC_RX_CRC16_EN
                            crc_d      = crc16_bit(crc_q, dly_q[DLY-1]);
`endif
                            if (pack_cnt_q == 3'd7) begin
                                if (byte_cnt_q == MAX_CNT) begin
                                    out_abort_d = 1'b1;
                                    mode_d      = HUNT;
                                    clr         = 1'b1;
                                end else begin
                                    byte_cnt_d   = byte_cnt_q + CW'(1);
                                    in_frame_d   = 1'b1;
                                    hold_d       = byte_v;
                                    hold_vld_d   = 1'b1;
                                    hold_first_d = (byte_cnt_q == '0);
                                    out_valid_d  = hold_vld_q;
                                    out_sof_d    = hold_vld_q && hold_first_q;
                                    if (hold_vld_q) begin
                                        out_data_d = hold_q;
                                    end
                                end
                            end
                        end
                    end
                end
            endcase
        end
        if (clr) begin
            dly_cnt_d    = 3'd0;
            pack_cnt_d   = 3'd0;
            hold_vld_d   = 1'b0;
            hold_first_d = 1'b0;
            byte_cnt_d   = '0;
            in_frame_d   = 1'b0;
`ifdef HDLC_RX_CRC16_EN
            crc_d        = CRC_INIT;
`endif
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            mode_q       <= HUNT;
            dly_q        <= '0;
            dly_cnt_q    <= 3'd0;
            pack_q       <= '0;
            pack_cnt_q   <= 3'd0;
            hold_q       <= '0;
            hold_vld_q   <= 1'b0;
            hold_first_q <= 1'b0;
            byte_cnt_q   <= '0;
            in_frame_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_sof_q    <= 1'b0;
            out_eof_q    <= 1'b0;
            out_abort_q  <= 1'b0;
`ifdef HDLC_RX_CRC16_EN
            crc_q        <= CRC_INIT;
            crc_err_q    <= 1'b0;
`endif
        end else begin
            mode_q       <= mode_d;
            dly_q        <= dly_d;
            dly_cnt_q    <= dly_cnt_d;
            pack_q       <= pack_d;
            pack_cnt_q   <= pack_cnt_d;
            hold_q       <= hold_d;
            hold_vld_q   <= hold_vld_d;
            hold_first_q <= hold_first_d;
            byte_cnt_q   <= byte_cnt_d;
            in_frame_q   <= in_frame_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_sof_q    <= out_sof_d;
            out_eof_q    <= out_eof_d;
            out_abort_q  <= out_abort_d;
`ifdef HDLC_RX_CRC16_EN
            crc_q        <= crc_d;
            crc_err_q    <= crc_err_d;
`endif
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sof   = out_sof_q;
    assign bus.out_eof   = out_eof_q;
    assign bus.out_abort = out_abort_q;
    assign bus.in_frame  = in_frame_q;
`ifdef HDLC_RX_CRC16_EN
    assign bus.out_crc_err = crc_err_q;
`else
    assign bus.out_crc_err = 1'b0;
`endif

endmodule

// File: tb/tb_hdlc_rx_deframer.sv
// Directed testbench for hdlc_rx_deframer: bit-stuffed frames with hand-derived results,
// reset, abort, stuffing, in_valid gaps, byte-limit and (when enabled) FCS cases.
module tb_hdlc_rx_deframer;

    localparam int MON_DEPTH = 2048;
`ifdef HDLC_RX_CRC16_EN
    localparam bit CRC_ON = 1'b1;
`else
    localparam bit CRC_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic aresetn = 1'b0;
    always #5 clk = ~clk;

    hdlc_rx_deframer_if bus ();

    hdlc_rx_deframer #(.MAX_BYTES(256)) dut (
        .clk    (clk),
        .aresetn(aresetn),
        .bus    (bus)
    );

    int total = 0;
    int bad   = 0;
    int ones  = 0;
    bit gap   = 1'b0;

    int         n_valid = 0;
    int         n_eof   = 0;
    int         n_abort = 0;
    logic [7:0] last_data = '0;
    logic [7:0] v_data [MON_DEPTH];
    logic       v_sof  [MON_DEPTH];
    logic       v_eof  [MON_DEPTH];
    logic       v_crc  [MON_DEPTH];

    always @(negedge clk) begin
        if (aresetn) begin
            if (bus.out_valid) begin
                if (n_valid < MON_DEPTH) begin
                    v_data[n_valid] <= bus.out_data;
                    v_sof[n_valid]  <= bus.out_sof;
                    v_eof[n_valid]  <= bus.out_eof;
                    v_crc[n_valid]  <= bus.out_crc_err;
                end
                last_data <= bus.out_data;
                n_valid   <= n_valid + 1;
                if (bus.out_eof) n_eof <= n_eof + 1;
            end
            if (bus.out_abort) n_abort <= n_abort + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        bus.in       = b;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        if (gap) begin
            bus.in = ~b;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_flag();
        logic [7:0] f;
        f = 8'h7E;
        for (int i = 0; i < 8; i++) send_bit(f[i]);
        ones = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            send_bit(b[i]);
            ones = b[i] ? ones + 1 : 0;
            if (ones == 5) begin
                send_bit(1'b0);
                ones = 0;
            end
        end
    endtask

    task automatic send_raw(input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) send_bit(bits[i]);
        ones = 0;
    endtask

    function automatic logic [15:0] crc_byte(input logic [15:0] c_in, input logic [7:0] d);
        logic [15:0] c;
        c = c_in ^ {8'h00, d};
        for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
        return c;
    endfunction

    initial begin
        int b, a0, e0;
        logic [15:0] fcs;
        bus.in_valid = 1'b0;
        bus.in       = 1'b0;

        // Reset values
        idle(3);
        aresetn = 1'b1;
        idle(1);
        check("rst_valid", bus.out_valid, 0);
        check("rst_data", bus.out_data, 0);
        check("rst_sof_eof", {bus.out_sof, bus.out_eof}, 0);
        check("rst_abort", bus.out_abort, 0);
        check("rst_crc", bus.out_crc_err, 0);
        check("rst_in_frame", bus.in_frame, 0);

        // Reset mid-frame: silent discard
        a0 = n_abort; b = n_valid;
        send_flag(); send_byte(8'hA5); send_byte(8'h3C);
        check("mid_in_frame", bus.in_frame, 1);
        #2 aresetn = 1'b0;
        #1;
        check("mid_rst_in_frame", bus.in_frame, 0);
        check("mid_rst_abort", bus.out_abort, 0);
        idle(2);
        aresetn = 1'b1;
        ones = 0;
        // Flag-less data is ignored
        send_byte(8'h00); send_byte(8'h55); send_byte(8'h0F); send_byte(8'h12);
        idle(2);
        check("noflag_valid", n_valid - b, 0);
        check("noflag_abort", n_abort - a0, 0);

        // Two-byte frame
        b = n_valid; a0 = n_abort;
        send_flag(); send_byte(8'hA5); send_byte(8'h3C);
        check("t2_in_frame", bus.in_frame, 1);
        send_flag();
        idle(2);
        check("t2_count", n_valid - b, 2);
        check("t2_b0", {v_sof[b], v_eof[b], v_data[b]}, {2'b10, 8'hA5});
        check("t2_b1", {v_sof[b+1], v_eof[b+1], v_data[b+1]}, {2'b01, 8'h3C});
        check("t2_crc", v_crc[b+1], 32'(CRC_ON));
        check("t2_abort", n_abort - a0, 0);
        check("t2_in_frame_end", bus.in_frame, 0);

        // 0xFF with stuffed zero, then idle ones (no abort when nothing open)
        b = n_valid; a0 = n_abort;
        send_flag(); send_byte(8'hFF); send_flag();
        send_raw(16'h03FF, 10);
        idle(2);
        check("t3_count", n_valid - b, 1);
        check("t3_b0", {v_sof[b], v_eof[b], v_data[b]}, {2'b11, 8'hFF});
        check("t3_idle_abort", n_abort - a0, 0);

        // Seven ones abort an open frame; later data ignored
        b = n_valid; a0 = n_abort; e0 = n_eof;
        send_flag(); send_byte(8'h12);
        send_raw(16'h007F, 7);
        send_raw(16'h0034, 8);
        idle(2);
        check("t4_abort", n_abort - a0, 1);
        check("t4_eof", n_eof - e0, 0);
        check("t4_valid", n_valid - b, 0);
        check("t4_in_frame", bus.in_frame, 0);

        // 12 bits then flag -> abort; back-to-back flag then a good frame
        b = n_valid; a0 = n_abort; e0 = n_eof;
        send_flag(); send_byte(8'hA5); send_raw(16'h0005, 4);
        send_flag();
        idle(1);
        check("t5_abort", n_abort - a0, 1);
        check("t5_eof", n_eof - e0, 0);
        send_flag(); send_byte(8'h55); send_flag();
        idle(2);
        check("t5_count", n_valid - b, 1);
        check("t5_b0", {v_sof[b], v_eof[b], v_data[b]}, {2'b11, 8'h55});
        check("t5_abort_total", n_abort - a0, 1);

        // FCS: valid frame, then a payload bit flipped
        fcs = ~crc_byte(16'hFFFF, 8'h01);
        b = n_valid;
        send_flag(); send_byte(8'h01); send_byte(fcs[7:0]); send_byte(fcs[15:8]); send_flag();
        idle(2);
        check("t6_count", n_valid - b, 3);
        check("t6_fcs_out", {v_eof[b+2], v_data[b+2]}, {1'b1, fcs[15:8]});
        check("t6_crc_good", v_crc[b+2], 0);
        b = n_valid;
        send_flag(); send_byte(8'h03); send_byte(fcs[7:0]); send_byte(fcs[15:8]); send_flag();
        idle(2);
        check("t6_crc_bad", {v_eof[b+2], v_crc[b+2]}, {1'b1, CRC_ON});

        // in_valid gaps with junk on the line
        b = n_valid;
        gap = 1'b1;
        send_flag(); send_byte(8'hC3); send_flag();
        gap = 1'b0;
        idle(2);
        check("t7_count", n_valid - b, 1);
        check("t7_b0", {v_sof[b], v_eof[b], v_data[b]}, {2'b11, 8'hC3});

        // Exactly MAX_BYTES is accepted
        b = n_valid; a0 = n_abort; e0 = n_eof;
        send_flag();
        for (int i = 0; i < 256; i++) send_byte(8'(i));
        send_flag();
        idle(2);
        check("t8_count", n_valid - b, 256);
        check("t8_eof", n_eof - e0, 1);
        check("t8_last", last_data, 8'hFF);
        check("t8_abort", n_abort - a0, 0);

        // MAX_BYTES+1 aborts
        b = n_valid; a0 = n_abort; e0 = n_eof;
        send_flag();
        for (int i = 0; i < 257; i++) send_byte(8'(i));
        send_flag();
        idle(2);
        check("t9_abort", n_abort - a0, 1);
        check("t9_eof", n_eof - e0, 0);
        check("t9_count", n_valid - b, 255);
        check("t9_in_frame", bus.in_frame, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
